// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Shared definitions for the EtherNeco sync-timer master and slave: frame layout,
// command bits and helpers.
package jellyvl_etherneco_synctimer_pkg;

  localparam int unsigned CMD_CORRECT_BIT  = 0;
  localparam int unsigned CMD_OVERRIDE_BIT = 1;
  localparam int unsigned HDR_LEN          = 9;
  localparam int unsigned NODE_BYTES       = 4;

  typedef logic [4-1:0][8-1:0] t_offset;
  typedef logic [8-1:0][8-1:0] t_time;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitRes
  } state_e;

  function automatic logic [15:0] frame_len(input logic [7:0] nodes);
    return 16'(HDR_LEN) + {6'd0, nodes, 2'b00};
  endfunction

  function automatic logic [7:0] cmd_byte(input logic override_bit, input logic correct_bit);
    logic [7:0] b;
    b = '0;
    b[CMD_OVERRIDE_BIT] = override_bit;
    b[CMD_CORRECT_BIT]  = correct_bit;
    return b;
  endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_table.sv
// Per-node 32-bit register table with byte-lane writes, optional shadow/commit stage,
// a registered software read port and a combinational streaming read port.
module jellyvl_etherneco_synctimer_table #(
  parameter int unsigned MaxNodes  = 32,
  parameter bit          HasShadow = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_node_i,
  input  logic [3:0]  wr_strb_i,
  input  logic [31:0] wr_data_i,
  input  logic        commit_i,
  input  logic [7:0]  rd_node_i,
  output logic [31:0] rd_data_o,
  input  logic [7:0]  tx_node_i,
  output logic [31:0] tx_data_o
);

  logic [MaxNodes-1:0][31:0] vis_q, vis_d;
  logic [MaxNodes-1:0][31:0] shd_q, shd_d;
  logic [31:0]               rd_q, rd_d;

  // Node numbers are 1-based; 0 and anything past MaxNodes match no entry.
  always_comb begin
    vis_d     = vis_q;
    shd_d     = shd_q;
    rd_d      = '0;
    tx_data_o = '0;
    for (int i = 0; i < MaxNodes; i++) begin
      if (wr_en_i && (wr_node_i == 8'(i + 1))) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb_i[b]) begin
            if (HasShadow) begin
              shd_d[i][8*b +: 8] = wr_data_i[8*b +: 8];
            end else begin
              vis_d[i][8*b +: 8] = wr_data_i[8*b +: 8];
            end
          end
        end
      end
      if (rd_node_i == 8'(i + 1)) begin
        rd_d = vis_q[i];
      end
      if (tx_node_i == 8'(i + 1)) begin
        tx_data_o = vis_q[i];
      end
    end
    // Commit sees same-cycle shadow writes so a final byte is not lost.
    if (HasShadow && commit_i) begin
      vis_d = shd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vis_q <= '0;
      shd_q <= '0;
      rd_q  <= '0;
    end else begin
      vis_q <= vis_d;
      shd_q <= shd_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/jellyvl_etherneco_synctimer_master.sv
// Sync-timer ring master: periodically streams the time-sync command frame and captures
// per-node elapsed times from the returning response frame.
module jellyvl_etherneco_synctimer_master
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH    = 64,
  parameter int unsigned MAX_NODES      = 32,
  parameter int unsigned PERIOD_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [63:0] TX_TIME_ADJ    = 64'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [7:0]              node_count,
  input  logic                    cmd_override,
  input  logic                    cmd_correct,
  input  logic                    wr_en,
  input  logic [7:0]              wr_node,
  input  logic [31:0]             wr_offset,
  input  logic [7:0]              rd_node,
  output logic [31:0]             rd_elapsed,
  output logic                    m_cmd_first,
  output logic                    m_cmd_last,
  output logic [7:0]              m_cmd_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  input  logic                    res_rx_start,
  input  logic                    res_rx_end,
  input  logic                    res_rx_error,
  input  logic [15:0]             s_res_pos,
  input  logic [7:0]              s_res_data,
  input  logic                    s_res_valid,
  output logic                    busy,
  output logic                    res_done,
  output logic                    res_error,
  output logic                    res_timeout
);

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [31:0]             tout_cnt_q, tout_cnt_d;
  logic [15:0]             pos_q, pos_d;
  logic [15:0]             len_q, len_d;
  t_time                   time_q, time_d;
  t_offset                 word_q, word_d;
  logic                    valid_q, valid_d;
  logic                    first_q, first_d;
  logic                    last_q, last_d;
  logic [7:0]              data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    tout_q, tout_d;

  logic [7:0]  nodes_clamp;
  logic [15:0] npos, noff, tidx, res_off;
  logic [7:0]  tx_node, cap_node;
  logic [31:0] tx_word;
  logic        cap_en, commit;
  logic [3:0]  cap_strb;
  logic        unused_bits;

  assign nodes_clamp = (node_count > 8'(MAX_NODES)) ? 8'(MAX_NODES) : node_count;
  assign npos        = pos_q + 16'd1;
  assign tidx        = npos - 16'd1;
  assign noff        = npos - 16'(HDR_LEN);
  assign tx_node     = noff[9:2] + 8'd1;

  assign res_off  = s_res_pos - 16'(HDR_LEN);
  assign cap_node = res_off[9:2] + 8'd1;
  assign cap_strb = 4'b0001 << res_off[1:0];
  assign cap_en   = (state_q == StWaitRes) && s_res_valid &&
                    (s_res_pos >= 16'(HDR_LEN)) && (s_res_pos < len_q);
  assign commit   = (state_q == StWaitRes) && res_rx_end && !res_rx_error;

  assign unused_bits = ^{res_rx_start, noff[15:10], res_off[15:10], tidx[15:3]};

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tout_cnt_d = tout_cnt_q;
    pos_d      = pos_q;
    len_d      = len_q;
    time_d     = time_q;
    word_d     = word_q;
    valid_d    = valid_q;
    first_d    = first_q;
    last_d     = last_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tout_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          if (timer_q >= period) begin
            state_d = StSend;
            timer_d = '0;
            time_d  = t_time'(current_time[63:0] + TX_TIME_ADJ);
            len_d   = frame_len(nodes_clamp);
            pos_d   = '0;
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = 1'b0;
            data_d  = cmd_byte(cmd_override, cmd_correct);
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StSend: begin
        if (valid_q && m_cmd_ready) begin
          first_d = 1'b0;
          if (last_q) begin
            valid_d    = 1'b0;
            last_d     = 1'b0;
            state_d    = StWaitRes;
            tout_cnt_d = '0;
          end else begin
            pos_d  = npos;
            last_d = (npos == len_q - 16'd1);
            if (npos < 16'(HDR_LEN)) begin
              data_d = time_q[tidx[2:0]];
            end else if (noff[1:0] == 2'd0) begin
              // Whole offset word is latched at lane 0 so a mid-node write cannot tear it.
              word_d = tx_word;
              data_d = tx_word[7:0];
            end else begin
              data_d = word_q[noff[1:0]];
            end
          end
        end
      end
      StWaitRes: begin
        if (res_rx_error) begin
          err_d   = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end else if (res_rx_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end else if (tout_cnt_q >= 32'(TIMEOUT_CYCLES)) begin
          tout_d  = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end else begin
          tout_cnt_d = tout_cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      tout_cnt_q <= '0;
      pos_q      <= '0;
      len_q      <= '0;
      time_q     <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tout_cnt_q <= tout_cnt_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      time_q     <= time_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tout_q     <= tout_d;
    end
  end

  jellyvl_etherneco_synctimer_table #(
    .MaxNodes (MAX_NODES),
    .HasShadow(1'b0)
  ) u_offset_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en),
    .wr_node_i(wr_node),
    .wr_strb_i(4'hF),
    .wr_data_i(wr_offset),
    .commit_i (1'b0),
    .rd_node_i(8'd0),
    .rd_data_o(),
    .tx_node_i(tx_node),
    .tx_data_o(tx_word)
  );

  jellyvl_etherneco_synctimer_table #(
    .MaxNodes (MAX_NODES),
    .HasShadow(1'b1)
  ) u_elapsed_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (cap_en),
    .wr_node_i(cap_node),
    .wr_strb_i(cap_strb),
    .wr_data_i({4{s_res_data}}),
    .commit_i (commit),
    .rd_node_i(rd_node),
    .rd_data_o(rd_elapsed),
    .tx_node_i(8'd0),
    .tx_data_o()
  );

  assign m_cmd_valid = valid_q;
  assign m_cmd_first = first_q;
  assign m_cmd_last  = last_q;
  assign m_cmd_data  = data_q;
  assign busy        = (state_q != StIdle);
  assign res_done    = done_q;
  assign res_error   = err_q;
  assign res_timeout = tout_q;

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_master.sv
// Directed bench for the sync-timer master: frame content, handshake, response capture,
// error/timeout handling, node clamping and reset.
module tb_jellyvl_etherneco_synctimer_master;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset, enable, cmd_override, cmd_correct, wr_en, m_cmd_ready;
  logic        res_rx_start, res_rx_end, res_rx_error, s_res_valid;
  logic [63:0] current_time;
  logic [31:0] period, wr_offset, rd_elapsed;
  logic [7:0]  node_count, wr_node, rd_node, s_res_data, m_cmd_data;
  logic [15:0] s_res_pos;
  logic        m_cmd_first, m_cmd_last, m_cmd_valid, busy, res_done, res_error, res_timeout;

  int checks = 0;
  int failures = 0;

  logic [7:0] got_data  [0:255];
  logic       got_first [0:255];
  logic       got_last  [0:255];

  logic [7:0] exp_f1 [0:16] = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
  logic [7:0] exp_f4 [0:8]  = '{8'h02, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

  always #5 clk = ~clk;

  jellyvl_etherneco_synctimer_master #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .current_time(current_time),
    .enable      (enable),
    .period      (period),
    .node_count  (node_count),
    .cmd_override(cmd_override),
    .cmd_correct (cmd_correct),
    .wr_en       (wr_en),
    .wr_node     (wr_node),
    .wr_offset   (wr_offset),
    .rd_node     (rd_node),
    .rd_elapsed  (rd_elapsed),
    .m_cmd_first (m_cmd_first),
    .m_cmd_last  (m_cmd_last),
    .m_cmd_data  (m_cmd_data),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd_ready (m_cmd_ready),
    .res_rx_start(res_rx_start),
    .res_rx_end  (res_rx_end),
    .res_rx_error(res_rx_error),
    .s_res_pos   (s_res_pos),
    .s_res_data  (s_res_data),
    .s_res_valid (s_res_valid),
    .busy        (busy),
    .res_done    (res_done),
    .res_error   (res_error),
    .res_timeout (res_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound, output int cyc);
    cyc = 0;
    while (!m_cmd_valid && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Consume one frame; optionally rewrite node 1's offset when byte wr_pos is accepted.
  task automatic collect(input bit rnd, input int wr_pos, output int n, output int cyc);
    bit         hold, done_f;
    logic [7:0] hd;
    logic       hf, hl;
    n = 0; cyc = 0; hold = 0; done_f = 0; hd = '0; hf = 0; hl = 0;
    while (!done_f && cyc < 1000) begin
      wr_en = 1'b0;
      if (hold) begin
        check("hold_valid", m_cmd_valid, 1'b1);
        check("hold_data", m_cmd_data, hd);
        check("hold_first", m_cmd_first, hf);
        check("hold_last", m_cmd_last, hl);
      end
      m_cmd_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (m_cmd_valid && m_cmd_ready) begin
        got_data[n]  = m_cmd_data;
        got_first[n] = m_cmd_first;
        got_last[n]  = m_cmd_last;
        if (n == wr_pos) begin
          wr_en = 1'b1; wr_node = 8'd1; wr_offset = 32'hAABBCCDD;
        end
        if (m_cmd_last) done_f = 1;
        n++;
      end
      hold = m_cmd_valid && !m_cmd_ready;
      hd = m_cmd_data; hf = m_cmd_first; hl = m_cmd_last;
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
    m_cmd_ready = 1'b1;
    if (!done_f) check("frame_end_seen", 1'b0, 1'b1);
  endtask

  task automatic send_res(input logic [15:0] pos, input logic [7:0] d, input logic endf,
                          input logic errf);
    s_res_valid = 1'b1; s_res_pos = pos; s_res_data = d; res_rx_end = endf; res_rx_error = errf;
    @(negedge clk);
    s_res_valid = 1'b0; res_rx_end = 1'b0; res_rx_error = 1'b0;
  endtask

  initial begin
    int c, n, cy, nf, nl;
    bit seen;
    reset = 1'b1; enable = 1'b0; cmd_override = 1'b0; cmd_correct = 1'b0; wr_en = 1'b0;
    m_cmd_ready = 1'b1; res_rx_start = 1'b0; res_rx_end = 1'b0; res_rx_error = 1'b0;
    s_res_valid = 1'b0; current_time = '0; period = 32'd99; wr_offset = '0; node_count = 8'd2;
    wr_node = '0; rd_node = 8'd1; s_res_data = '0; s_res_pos = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", m_cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {res_done, res_error, res_timeout}, 3'b000);
    check("rst_rd_elapsed", rd_elapsed, 32'd0);
    reset = 1'b0;

    wr_en = 1'b1; wr_node = 8'd1; wr_offset = 32'h11223344;
    @(negedge clk); wr_node = 8'd2; wr_offset = 32'h55667788;
    @(negedge clk); wr_node = 8'd0; wr_offset = 32'hFFFFFFFF;
    @(negedge clk); wr_en = 1'b0;

    // Frame 1: fixed ready
    current_time = 64'h1000; cmd_correct = 1'b1; enable = 1'b1;
    wait_valid(300, c);
    check("f1_start_cycles", c, 100);
    collect(1'b0, -1, n, cy);
    check("f1_len", n, 17);
    check("f1_no_bubbles", cy, 17);
    nf = 0; nl = 0;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("f1_byte%0d", i), got_data[i], exp_f1[i]);
      nf += int'(got_first[i]); nl += int'(got_last[i]);
    end
    check("f1_first0", got_first[0], 1'b1);
    check("f1_last16", got_last[16], 1'b1);
    check("f1_flag_counts", {nf[7:0], nl[7:0]}, 16'h0101);
    check("wait_busy", busy, 1'b1);
    check("wait_valid_low", m_cmd_valid, 1'b0);

    send_res(16'd7, 8'h99, 1'b0, 1'b0);
    send_res(16'd8, 8'h99, 1'b0, 1'b0);
    send_res(16'd9, 8'h0A, 1'b0, 1'b0);
    send_res(16'd10, 8'h00, 1'b0, 1'b0);
    send_res(16'd11, 8'h00, 1'b0, 1'b0);
    send_res(16'd12, 8'h00, 1'b0, 1'b0);
    send_res(16'd13, 8'h78, 1'b0, 1'b0);
    send_res(16'd14, 8'h56, 1'b0, 1'b0);
    send_res(16'd15, 8'h34, 1'b0, 1'b0);
    send_res(16'd16, 8'h12, 1'b1, 1'b0);
    check("f1_res_done", {res_done, res_error, res_timeout}, 3'b100);
    check("f1_idle_busy", busy, 1'b0);
    rd_node = 8'd1;
    @(negedge clk);
    check("f1_elapsed_n1", rd_elapsed, 32'h0000000A);
    rd_node = 8'd2;
    @(negedge clk);
    check("f1_elapsed_n2_same_cycle_end", rd_elapsed, 32'h12345678);
    wait_valid(300, c);
    check("f2_restart_cycles", c + 2, 100);

    // Frame 2: random ready, identical content
    collect(1'b1, -1, n, cy);
    check("f2_len", n, 17);
    for (int i = 0; i < 17; i++) check($sformatf("f2_byte%0d", i), got_data[i], exp_f1[i]);
    send_res(16'd9, 8'h0B, 1'b0, 1'b0);
    send_res(16'd10, 8'h00, 1'b1, 1'b1);
    check("f2_res_error", {res_done, res_error, res_timeout}, 3'b010);
    check("f2_idle_busy", busy, 1'b0);
    period = 32'd9;
    rd_node = 8'd1;
    @(negedge clk);
    check("f2_elapsed_kept", rd_elapsed, 32'h0000000A);

    // Frame 3: enable dropped mid-frame, then timeout
    wait_valid(300, c);
    enable = 1'b0;
    collect(1'b0, -1, n, cy);
    check("f3_len_completes", n, 17);
    c = 0;
    while (!res_timeout && c < int'(TO) + 20) begin
      @(negedge clk);
      c++;
    end
    check("f3_timeout_window", (c >= int'(TO)) && (c <= int'(TO) + 2), 1'b1);
    check("f3_timeout_busy", busy, 1'b0);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_cmd_valid) seen = 1;
    end
    check("disabled_no_frame", seen, 1'b0);

    // Frame 4: zero nodes, override command, new timestamp
    node_count = 8'd0; cmd_override = 1'b1; cmd_correct = 1'b0;
    current_time = 64'h0123456789ABCDEF; enable = 1'b1;
    wait_valid(300, c);
    collect(1'b0, -1, n, cy);
    check("f4_len", n, 9);
    check("f4_last8", got_last[8], 1'b1);
    for (int i = 0; i < 9; i++) check($sformatf("f4_byte%0d", i), got_data[i], exp_f4[i]);
    send_res(16'd0, 8'h00, 1'b1, 1'b0);
    check("f4_res_done", res_done, 1'b1);

    // Frame 5: clamp to MAX_NODES, ignored writes, mid-node offset rewrite
    node_count = 8'd200;
    wr_en = 1'b1; wr_node = 8'd0; wr_offset = 32'hDEADBEEF;
    @(negedge clk); wr_node = 8'd33;
    @(negedge clk); wr_en = 1'b0;
    wait_valid(300, c);
    collect(1'b0, 10, n, cy);
    check("f5_len_clamped", n, 137);
    check("f5_last136", got_last[136], 1'b1);
    check("f5_b9", got_data[9], 8'h44);
    check("f5_b10", got_data[10], 8'h33);
    check("f5_b11_no_tear", got_data[11], 8'h22);
    check("f5_b12_no_tear", got_data[12], 8'h11);
    check("f5_b136_unwritten", got_data[136], 8'h00);
    send_res(16'd0, 8'h00, 1'b1, 1'b0);
    check("f5_res_done", res_done, 1'b1);

    // Frame 6: rewritten offset appears
    node_count = 8'd1;
    wait_valid(300, c);
    collect(1'b0, -1, n, cy);
    check("f6_len", n, 13);
    check("f6_b9", got_data[9], 8'hDD);
    check("f6_b12", got_data[12], 8'hAA);
    send_res(16'd0, 8'h00, 1'b1, 1'b0);

    // Frame 7: reset mid-SEND
    wait_valid(300, c);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", m_cmd_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_pulses", {res_done, res_error, res_timeout}, 3'b000);
    reset = 1'b0; enable = 1'b0; rd_node = 8'd1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_elapsed_cleared", rd_elapsed, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
